// File: rtl/barrett_pkg.sv
// Shared constants and elaboration-time helpers for the Barrett reducers.
package barrett_pkg;

  localparam int Q_DEFAULT = 383;
  localparam int K_DEFAULT = 9;

  // Smallest r with 2^r >= v; used to confirm K matches the modulus width.
  function automatic int clog2(input longint v);
    int     r;
    longint x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Barrett constant floor(2^(2k) / q).
  function automatic longint barrett_mu(input longint q, input int k);
    return (longint'(1) << (2 * k)) / q;
  endfunction

endpackage

// File: rtl/barrett_cond_sub.sv
// Two-step conditional subtract: maps x in [0, 3Q) to x mod Q.
// Purely combinational so modular adders can reuse it as a final fold.
module barrett_cond_sub
  #(parameter int Q = 383,
    parameter int W = 11)
  (input  logic [W-1:0] x,
   output logic [W-1:0] y);

  localparam logic [W-1:0] Q1 = W'(Q);
  localparam logic [W-1:0] Q2 = W'(2 * Q);

  // Subtract 2Q or Q depending on which range x falls in.
  always_comb begin
    y = x;
    if (x >= Q2) begin
      y = x - Q2;
    end else if (x >= Q1) begin
      y = x - Q1;
    end
  end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Three-stage pipelined Barrett reducer: dout_r = din_a mod Q, fully reduced.
//
// Handshake: a beat is taken on a rising edge when in_valid && in_ready and
// handed off when out_valid && out_ready. The whole pipe shares one enable,
// advance = !(out_valid && !out_ready); in_ready is that enable, so a stalled
// output freezes every stage (bubbles are not squeezed) and a consume and an
// accept can happen on the same edge.
module barrett_reduce_pipe
  import barrett_pkg::*;
  #(parameter int Q     = Q_DEFAULT,
    parameter int K     = K_DEFAULT,
    parameter int TAG_W = 4)
  (input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*K-1:0]   din_a,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [K-1:0]     dout_r,
   output logic [TAG_W-1:0] out_tag);

  localparam longint       MU_L = barrett_mu(Q, K);
  localparam logic [K:0]   MU   = (K+1)'(MU_L);
  localparam logic [K+1:0] Q_X  = (K+2)'(Q);

  if (K != clog2(Q)) begin : g_k_check
    $error("barrett_reduce_pipe: K must equal clog2(Q)");
  end
  if ((Q & (Q - 1)) == 0) begin : g_q_check
    $error("barrett_reduce_pipe: Q must not be a power of two");
  end

  logic advance;

  // S1 state. Only the low K+2 bits of the operand are kept: r < 3Q < 2^(K+2),
  // so a - t*Q is exact modulo 2^(K+2).
  logic             s1_valid;
  logic [K:0]       s1_t;
  logic [K+1:0]     s1_a;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [K+1:0]     s2_r;
  logic [TAG_W-1:0] s2_tag;

  logic [2*K:0]     prod;
  logic [K:0]       t_next;
  logic [K+1:0]     tq_lo;
  logic [K+1:0]     r_next;
  logic [K+1:0]     red;

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // Quotient estimate t = ((a >> K) * MU) >> K on the full-width product.
  always_comb begin
    prod   = {{(K+1){1'b0}}, din_a[2*K-1:K]} * {{K{1'b0}}, MU};
    t_next = (K+1)'(prod >> K);
  end

  // Remainder estimate r = a - t*Q, kept in K+2 bits.
  always_comb begin
    tq_lo  = {1'b0, s1_t} * Q_X;
    r_next = s1_a - tq_lo;
  end

  barrett_cond_sub #(.Q(Q), .W(K+2)) u_cond_sub (
    .x (s2_r),
    .y (red)
  );

  // Stage 1: capture quotient estimate, low operand bits and tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_t     <= '0;
      s1_a     <= '0;
      s1_tag   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_t     <= t_next;
      s1_a     <= din_a[K+1:0];
      s1_tag   <= in_tag;
    end
  end

  // Stage 2: capture the partially reduced remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_r     <= '0;
      s2_tag   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_r     <= r_next;
      s2_tag   <= s1_tag;
    end
  end

  // Stage 3: capture the fully reduced result; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout_r    <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      out_valid <= s2_valid;
      dout_r    <= K'(red);
      out_tag   <= s2_tag;
    end
  end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Bench for barrett_reduce_pipe: default Q=383 instance plus a Q=3329 instance.
module tb_barrett_reduce_pipe;

  localparam int Q  = 383;
  localparam int K  = 9;
  localparam int QB = 3329;
  localparam int KB = 12;
  localparam int TW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT A (Q=383) ----------------
  logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [2*K-1:0]  a_din;
  logic [TW-1:0]   a_in_tag, a_out_tag;
  logic [K-1:0]    a_dout;

  barrett_reduce_pipe #(.Q(Q), .K(K), .TAG_W(TW)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .din_a     (a_din),
    .in_tag    (a_in_tag),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .dout_r    (a_dout),
    .out_tag   (a_out_tag)
  );

  // ---------------- DUT B (Q=3329) ----------------
  logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2*KB-1:0] b_din;
  logic [TW-1:0]   b_in_tag, b_out_tag;
  logic [KB-1:0]   b_dout;

  barrett_reduce_pipe #(.Q(QB), .K(KB), .TAG_W(TW)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .din_a     (b_din),
    .in_tag    (b_in_tag),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .dout_r    (b_dout),
    .out_tag   (b_out_tag)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;
  bit            check_lat = 1'b1;
  logic [K-1:0]  exp_q[$];
  logic [TW-1:0] tag_q[$];
  int            lat_q[$];
  logic [KB-1:0] exp_b_q[$];
  logic [TW-1:0] tag_b_q[$];
  bit            stalled_prev = 1'b0;
  logic [K-1:0]  held_d;
  logic [TW-1:0] held_t;
  bit            last_ov;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [K-1:0] model_a(input logic [2*K-1:0] a);
    return K'(int'(a) % Q);
  endfunction

  function automatic logic [KB-1:0] model_b(input logic [2*KB-1:0] a);
    return KB'(int'(a) % QB);
  endfunction

  // ---------------- driver / monitor for DUT A ----------------
  // Drives one cycle's inputs, then evaluates both handshakes just before the edge.
  task automatic cycle_a(input bit v, input logic [2*K-1:0] a, input logic [TW-1:0] t,
                         input bit ordy, input logic [K-1:0] e, output bit acc);
    logic [K-1:0]  ed;
    logic [TW-1:0] et;
    int            l;
    @(negedge clk);
    a_in_valid  = v;
    a_din       = a;
    a_in_tag    = t;
    a_out_ready = ordy;
    #1;
    if (stalled_prev) begin
      check("stall_valid", 32'(a_out_valid), 32'd1);
      check("stall_dout", 32'(a_dout), 32'(held_d));
      check("stall_tag", 32'(a_out_tag), 32'(held_t));
    end
    check("in_ready", 32'(a_in_ready), 32'(!(a_out_valid && !ordy)));
    if (a_out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        ed = exp_q.pop_front();
        et = tag_q.pop_front();
        l  = lat_q.pop_front();
        check("dout", 32'(a_dout), 32'(ed));
        check("tag", 32'(a_out_tag), 32'(et));
        check("dout_lt_q", 32'(a_dout < K'(Q)), 32'd1);
        if (check_lat) check("latency", 32'(cyc - l), 32'd3);
        else           check("latency_min", 32'(cyc - l >= 3), 32'd1);
      end
    end
    acc = v && a_in_ready;
    if (acc) begin
      exp_q.push_back(e);
      tag_q.push_back(t);
      lat_q.push_back(cyc);
    end
    last_ov      = a_out_valid;
    stalled_prev = a_out_valid && !ordy;
    held_d       = a_dout;
    held_t       = a_out_tag;
    cyc++;
  endtask

  task automatic drain_a(input int max_cyc);
    bit acc;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      cycle_a(1'b0, '0, '0, 1'b1, '0, acc);
      n++;
    end
    check("drain_a_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- driver / monitor for DUT B (out_ready held high) ----------------
  task automatic cycle_b(input bit v, input logic [2*KB-1:0] a, input logic [TW-1:0] t,
                         input logic [KB-1:0] e);
    logic [KB-1:0] ed;
    logic [TW-1:0] et;
    @(negedge clk);
    b_in_valid  = v;
    b_din       = a;
    b_in_tag    = t;
    b_out_ready = 1'b1;
    #1;
    if (b_out_valid) begin
      if (exp_b_q.size() == 0) begin
        check("b_unexpected_out", 32'd1, 32'd0);
      end else begin
        ed = exp_b_q.pop_front();
        et = tag_b_q.pop_front();
        check("b_dout", 32'(b_dout), 32'(ed));
        check("b_tag", 32'(b_out_tag), 32'(et));
      end
    end
    if (v && b_in_ready) begin
      exp_b_q.push_back(e);
      tag_b_q.push_back(t);
    end
  endtask

  // ---------------- directed vectors ----------------
  // Q=383: 383^2 = 146689 (r lands exactly on Q inside the pipe),
  // 2^18-1 = 261972 + 171 where 261972 = 383*684.
  localparam int NDIR_A = 7;
  int dir_a_in [NDIR_A] = '{0, 383, 146689, 146688, 262143, 765, 766};
  int dir_a_exp[NDIR_A] = '{0, 0,   0,      382,    171,    382, 0};

  // Q=3329: 3329^2 = 11082241; 2^24-1 = 3329*5039 + 2384 (3329*5039 = 16774831).
  localparam int NDIR_B = 5;
  int dir_b_in [NDIR_B] = '{0, 3329, 11082241, 11082240, 16777215};
  int dir_b_exp[NDIR_B] = '{0, 0,    0,        3328,     2384};

  bit pat_a[12];
  bit obs_a[12];

  initial begin
    bit            acc;
    logic [2*K-1:0] av;
    logic [2*KB-1:0] bv;
    logic [TW-1:0] tg;

    rst_n       = 1'b0;
    a_in_valid  = 1'b0; a_din = '0; a_in_tag = '0; a_out_ready = 1'b1;
    b_in_valid  = 1'b0; b_din = '0; b_in_tag = '0; b_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_dout", 32'(a_dout), 32'd0);
    check("rst_out_tag", 32'(a_out_tag), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    rst_n = 1'b1;

    // Boundary operands, back to back.
    for (int i = 0; i < NDIR_A; i++)
      cycle_a(1'b1, (2*K)'(dir_a_in[i]), TW'(i), 1'b1, K'(dir_a_exp[i]), acc);
    drain_a(20);

    // Strided sweep over the operand space at full throughput.
    tg = '0;
    for (int i = 0; i < 20000; i++) begin
      av = (2*K)'(i * 13);
      cycle_a(1'b1, av, tg, 1'b1, model_a(av), acc);
      tg = tg + 1'b1;
    end
    av = '1;
    cycle_a(1'b1, av, tg, 1'b1, model_a(av), acc);
    drain_a(20);

    // Bubble pattern 1,0,1,0,... must reappear on out_valid three cycles later.
    for (int i = 0; i < 12; i++) begin
      pat_a[i] = (i % 2 == 0) && (i < 8);
      av = (2*K)'($urandom_range(0, 262143));
      cycle_a(pat_a[i], av, TW'(i), 1'b1, model_a(av), acc);
      obs_a[i] = last_ov;
    end
    for (int i = 3; i < 12; i++)
      check("bubble_valid", 32'(obs_a[i]), 32'(pat_a[i-3]));
    drain_a(20);

    // Continuous input with out_ready high 30% of the time.
    check_lat = 1'b0;
    tg = '0;
    for (int i = 0; i < 3000; i++) begin
      av  = (2*K)'($urandom_range(0, 262143));
      acc = 1'b0;
      while (!acc)
        cycle_a(1'b1, av, tg, ($urandom_range(0, 99) < 30), model_a(av), acc);
      tg = tg + 1'b1;
    end
    drain_a(40);
    check_lat = 1'b1;

    // Asynchronous reset with three beats in flight.
    cycle_a(1'b1, 18'd1000, 4'd1, 1'b1, model_a(18'd1000), acc);
    cycle_a(1'b1, 18'd2000, 4'd2, 1'b1, model_a(18'd2000), acc);
    cycle_a(1'b1, 18'd3000, 4'd3, 1'b1, model_a(18'd3000), acc);
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    check("pre_rst_valid", 32'(a_out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(a_out_valid), 32'd0);
    check("async_rst_dout", 32'(a_dout), 32'd0);
    check("async_rst_tag", 32'(a_out_tag), 32'd0);
    exp_q.delete();
    tag_q.delete();
    lat_q.delete();
    stalled_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle_a(1'b1, 18'd77777, 4'd9, 1'b1, model_a(18'd77777), acc);
    drain_a(20);
    for (int i = 0; i < 4; i++)
      cycle_a(1'b0, '0, '0, 1'b1, '0, acc);

    // Q=3329 instance: directed boundaries then random operands.
    for (int i = 0; i < NDIR_B; i++)
      cycle_b(1'b1, (2*KB)'(dir_b_in[i]), TW'(i), KB'(dir_b_exp[i]));
    tg = '0;
    for (int i = 0; i < 3000; i++) begin
      bv = (2*KB)'($urandom_range(0, 24'hFFFFFF));
      cycle_b(1'b1, bv, tg, model_b(bv));
      tg = tg + 1'b1;
    end
    for (int i = 0; i < 10 && exp_b_q.size() > 0; i++)
      cycle_b(1'b0, '0, '0, '0);
    check("drain_b_empty", 32'(exp_b_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
